// File: rtl/window_accumulator.sv
// ---------------------------------------------------------------------------
// window_accumulator
// Sums a stream of unsigned IN_W-bit samples over a 2**WIN_LOG2-sample window
// and presents the SUM_W-bit total to the downstream window-average multiplier.
//
// Build option (macro): SLIDING_WINDOW_EN
//   undefined : tumbling windows, one sum per 256 accepted samples
//   defined   : sliding window with a circular sample history; after the first
//               full window, a new sum is produced for every accepted sample
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous reset, active low
//   en           in   1      1 = accumulate, 0 = stop and discard partial window
//   clear        in   1      synchronous clear, overrides en/sample_valid
//   sample_in    in   IN_W   unsigned sample
//   sample_valid in   1      sample qualifier
//   sum_out      out  SUM_W  last completed window sum, held between updates
//   sum_valid    out  1      one-cycle pulse when sum_out has just updated
//   busy         out  1      1 while not IDLE
// ---------------------------------------------------------------------------
module window_accumulator #(
    parameter int unsigned IN_W     = 3,
    parameter int unsigned WIN_LOG2 = 8,
    parameter int unsigned SUM_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic [IN_W-1:0]   sample_in,
    input  logic              sample_valid,
    output logic [SUM_W-1:0]  sum_out,
    output logic              sum_valid,
    output logic              busy
);

    localparam int unsigned WIN_LEN = 1 << WIN_LOG2;

`ifdef SLIDING_WINDOW_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1
    } state_t;
`endif

    state_t              r_state;
    logic [SUM_W-1:0]    r_acc;
    logic [WIN_LOG2-1:0] r_cnt;       // samples in window; doubles as history write pointer
    logic [SUM_W-1:0]    r_sum_out;
    logic                r_sum_valid;
    logic                r_busy;

    logic [SUM_W-1:0]    w_acc_add;
    logic                w_last;
    logic                w_accept;

    assign w_acc_add = r_acc + SUM_W'(sample_in);
    assign w_last    = (r_cnt == {WIN_LOG2{1'b1}});
    assign w_accept  = en && sample_valid && !clear && (r_state != S_IDLE);

`ifdef SLIDING_WINDOW_EN
    // Circular history of the last WIN_LEN accepted samples; contents need no reset
    logic [IN_W-1:0]  r_hist [WIN_LEN];
    logic [IN_W-1:0]  w_hist_rd;
    logic [SUM_W-1:0] w_acc_slide;

    assign w_hist_rd   = r_hist[r_cnt];
    // acc always holds the sum of the window containing hist[wp], so no underflow
    assign w_acc_slide = w_acc_add - SUM_W'(w_hist_rd);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hist[r_cnt] <= sample_in;
        end
    end
`endif

    // Control FSM, accumulator and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum_out   <= '0;
            r_sum_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (clear) begin
                r_state   <= S_IDLE;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_sum_out <= '0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // Entering the window takes a cycle; no sample accepted here
                        if (en) begin
`ifdef SLIDING_WINDOW_EN
                            r_state <= S_FILL;
`else
                            r_state <= S_ACCUM;
`endif
                            r_busy  <= 1'b1;
                        end
                    end
`ifdef SLIDING_WINDOW_EN
                    S_FILL: begin
                        if (!en) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                        end else if (sample_valid) begin
                            r_acc <= w_acc_add;
                            r_cnt <= r_cnt + WIN_LOG2'(1);
                            if (w_last) begin
                                r_sum_out   <= w_acc_add;
                                r_sum_valid <= 1'b1;
                                r_state     <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (!en) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                        end else if (sample_valid) begin
                            r_acc       <= w_acc_slide;
                            r_sum_out   <= w_acc_slide;
                            r_sum_valid <= 1'b1;
                            r_cnt       <= r_cnt + WIN_LOG2'(1);
                        end
                    end
`else
                    S_ACCUM: begin
                        if (!en) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                        end else if (sample_valid) begin
                            // Counter wraps to 0 on the closing sample
                            r_cnt <= r_cnt + WIN_LOG2'(1);
                            if (w_last) begin
                                r_sum_out   <= w_acc_add;
                                r_sum_valid <= 1'b1;
                                r_acc       <= '0;
                            end else begin
                                r_acc <= w_acc_add;
                            end
                        end
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign sum_out   = r_sum_out;
    assign sum_valid = r_sum_valid;
    assign busy      = r_busy;

endmodule
